// File: rtl/fir_tap_engine.sv
// FIR tap engine: runs a TAPS-deep unsigned FIR over strobed samples, drains the
// delay line with zeros on halt, and exposes a coefficient bank writable in IDLE.
module fir_tap_engine #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 3,
  parameter int OUT_W  = 10,
  parameter int CNT_W  = 9,
  localparam int IDX_W = (TAPS > 2) ? $clog2(TAPS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              coef_we_i,
  input  logic [IDX_W-1:0]  coef_idx_i,
  input  logic [COEF_W-1:0] coef_data_i,
  output logic              out_valid_o,
  output logic [OUT_W-1:0]  out_o,
  output logic              done_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  out_cnt_o
);

  localparam int DCW = (TAPS > 2) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CAL   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   x_q    [TAPS];
  logic [DATA_W-1:0]   x_d    [TAPS];
  logic [COEF_W-1:0]   coef_q [TAPS];
  logic [COEF_W-1:0]   coef_d [TAPS];
  logic [DCW-1:0]      drain_q, drain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                shift;
  logic [DATA_W-1:0]   shift_val;
  logic [OUT_W-1:0]    acc;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    coef_d      = coef_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    shift       = 1'b0;
    shift_val   = '0;
    acc         = '0;

    case (state_q)
      S_IDLE: begin
        if (coef_we_i && (32'(coef_idx_i) < TAPS)) begin
          coef_d[coef_idx_i] = coef_data_i;
        end
        if (start_i) begin
          state_d = S_CAL;
          for (int k = 0; k < TAPS; k++) x_d[k] = '0;
          cnt_d = '0;
        end
      end
      S_CAL: begin
        if (in_valid_i) begin
          shift     = 1'b1;
          shift_val = in_i;
        end
        if (halt_i) begin
          state_d = S_DRAIN;
          drain_d = DCW'(TAPS - 2);
        end
      end
      S_DRAIN: begin
        shift = 1'b1;
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The result is formed from the post-shift line so it registers on the same edge as the shift.
    if (shift) begin
      for (int k = TAPS - 1; k > 0; k--) x_d[k] = x_q[k-1];
      x_d[0] = shift_val;
      for (int k = 0; k < TAPS; k++) begin
        acc = acc + OUT_W'(coef_q[k]) * OUT_W'(x_d[k]);
      end
      out_d       = acc;
      out_valid_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= COEF_W'(3 + k);
      end
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign done_o      = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_cnt_o   = cnt_q;

endmodule

// File: doc/fir_tap_engine.md
FIR_TAP_ENGINE -- requirements
Module: fir_tap_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 4, sample width (unsigned).
- COEF_W, 4, coefficient width (unsigned).
- TAPS, 3, tap count; legal range 2..16.
- OUT_W, 10, result width; legal only if OUT_W >= DATA_W+COEF_W+ceil(log2(TAPS)).
- CNT_W, 9, output-counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin a run.
- halt, in, 1, end sample input and begin drain.
- in_valid, in, 1, sample strobe.
- in, in, DATA_W, sample.
- coef_we, in, 1, coefficient write strobe.
- coef_idx, in, max(1,ceil(log2(TAPS))), coefficient index.
- coef_data, in, COEF_W, coefficient value.
- out_valid, out, 1, result strobe.
- out, out, OUT_W, filter result.
- done, out, 1, run-complete pulse.
- busy, out, 1, high in CAL, DRAIN or DONE.
- out_cnt, out, CNT_W, results produced in the current run.

REQ-003 One clock domain SHALL be used; reset SHALL be synchronous and active-high, sampled on the rising edge of clk.

Function
REQ-004 The FSM SHALL have states IDLE, CAL, DRAIN and DONE, all registered.
REQ-005 In IDLE, start=1 SHALL move to CAL next cycle, clear all delay-line entries to 0 and clear out_cnt to 0; start=0 SHALL stay in IDLE.
REQ-006 In CAL, in_valid=1 SHALL shift `in` into delay line x[0] (x[k] takes x[k-1]); in_valid=0 SHALL hold the delay line.
REQ-007 Every shift SHALL produce, one cycle later, out_valid=1 and out = sum over k=0..TAPS-1 of coef[k]*x[k], using the post-shift line; arithmetic SHALL be unsigned and full precision, with no truncation.
REQ-008 out SHALL hold its last value while out_valid=0; out_valid SHALL be a single-cycle strobe per shift.
REQ-009 In CAL, halt=1 SHALL move to DRAIN next cycle; if in_valid=1 in the same cycle, that sample SHALL be accepted first.
REQ-010 DRAIN SHALL last exactly TAPS-1 cycles, shifting 0 into x[0] each cycle; each shift SHALL produce a result per REQ-007; an internal counter SHALL track the drain cycles.
REQ-011 After the last drain cycle the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-012 start in CAL, DRAIN or DONE SHALL be ignored; halt outside CAL SHALL be ignored; in_valid outside CAL SHALL be ignored.
REQ-013 coef_we=1 in IDLE SHALL write coef_data to coef[coef_idx] at the clock edge; writes in other states, or with coef_idx >= TAPS, SHALL be ignored.
REQ-014 out_cnt SHALL increment on every out_valid and saturate at 2^CNT_W-1; it SHALL keep its value in IDLE until the next start.
REQ-015 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-016 rst=1 SHALL force, at the next edge:
- state=IDLE, delay line=0, drain counter=0;
- out=0, out_valid=0, done=0, busy=0, out_cnt=0;
- coef[k] = (3+k) mod 2^COEF_W.
REQ-017 rst SHALL override every other input, in any state, including mid-CAL and mid-DRAIN; no done pulse SHALL follow an aborted run.

Verification
REQ-018 Defaults, start, then samples 1,2,3 on consecutive cycles, then halt -> out = 3, 10, 22, 22, 15 (out_valid each, 1-cycle latency); done one cycle after the last result; out_cnt=5.
REQ-019 In IDLE write coef 15,15,15, start, feed 15,15,15, halt -> third result=675 with no overflow; then drain results 450, 225.
REQ-020 halt and in_valid (in=7) in the same CAL cycle under default coefs -> 7 accepted (out=21), then exactly 2 drain results (28, 35), then done.
REQ-021 rst asserted during DRAIN -> next cycle busy=0, out=0, out_cnt=0, coefs back to 3,4,5; no done pulse.
REQ-022 coef_we in CAL -> coefs unchanged; start in CAL -> no re-clear; with CNT_W=2, 5 results -> out_cnt stays at 3.
